// File: rtl/xoodoo_nc_inv_if.sv
// Strobe interface between a consumer of forward Xoodoo-NC output and the inverse block.
// dv is taken on a clock edge only while busy=0, with no queueing. out_valid pulses for one cycle when out updates.
interface xoodoo_nc_inv_if;
  logic        dv;
  logic [95:0] state;
  logic        busy;
  logic [95:0] out;
  logic        out_valid;
  logic        dbg_state;

  modport master (output dv, state, input busy, out, out_valid, dbg_state);
  modport slave  (input dv, state, output busy, out, out_valid, dbg_state);
endinterface

// File: rtl/xoodoo_nc_inv.sv
// Iterative inverse of the 3-lane reduced-round Xoodoo-NC permutation.
// Each clock runs one inverse round through one shared combinational datapath.
module xoodoo_nc_inv #(
  parameter int unsigned ROUNDS   = 3,
  parameter int unsigned FIRST_RC = 8,
  parameter logic [31:0] RC_0  = 32'h58,
  parameter logic [31:0] RC_1  = 32'h38,
  parameter logic [31:0] RC_2  = 32'h3C0,
  parameter logic [31:0] RC_3  = 32'hD0,
  parameter logic [31:0] RC_4  = 32'h120,
  parameter logic [31:0] RC_5  = 32'h14,
  parameter logic [31:0] RC_6  = 32'h60,
  parameter logic [31:0] RC_7  = 32'h2C,
  parameter logic [31:0] RC_8  = 32'h380,
  parameter logic [31:0] RC_9  = 32'hF0,
  parameter logic [31:0] RC_10 = 32'h1A0,
  parameter logic [31:0] RC_11 = 32'h12
) (
  input logic              clk,
  input logic              rst,
  xoodoo_nc_inv_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Padded to 16 entries so every 4-bit index is in range.
  localparam logic [31:0] RC_TAB [16] = '{RC_0, RC_1, RC_2, RC_3, RC_4, RC_5,
                                          RC_6, RC_7, RC_8, RC_9, RC_10, RC_11,
                                          32'h0, 32'h0, 32'h0, 32'h0};

  state_t      st;
  logic [95:0] work;
  logic [3:0]  cnt;
  logic        busy_q;
  logic        out_valid_q;
  logic [95:0] out_q;
  logic [3:0]  rc_idx;
  logic [95:0] round_out;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] g(input logic [31:0] v, input int a, input int b);
    return v ^ rotl(v, a) ^ rotl(v, b);
  endfunction

  function automatic logic [95:0] inv_round(input logic [95:0] s, input logic [31:0] rc);
    logic [31:0] a0, a1, a2, b0, b1, b2, pp, p, e;
    a0 = s[31:0];
    a1 = rotr(s[63:32], 1);
    a2 = rotr(s[95:64], 8);
    // 3-lane chi is its own inverse; all B terms use the pre-update lanes.
    b0 = ~a1 & a2;
    b1 = ~a2 & a0;
    b2 = ~a0 & a1;
    a0 = a0 ^ b0 ^ rc;
    a1 = a1 ^ b1;
    a2 = rotr(a2 ^ b2, 11);
    // f^32 is the identity, so f^31 inverts theta's column-parity map.
    pp = a0 ^ a1 ^ a2;
    p  = rotl(g(g(g(g(pp, 5, 14), 10, 28), 20, 24), 8, 16), 16);
    e  = p ^ pp;
    return {a2 ^ e, a1 ^ e, a0 ^ e};
  endfunction

  assign rc_idx    = 4'(FIRST_RC) + cnt;
  assign round_out = inv_round(work, RC_TAB[rc_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      work        <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.dv) begin
            work   <= bus.state;
            cnt    <= 4'(ROUNDS - 1);
            busy_q <= 1'b1;
            st     <= RUN;
          end
        end
        RUN: begin
          work <= round_out;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            out_q       <= round_out;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            st          <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.dbg_state = st;

endmodule

// File: tb/tb_xoodoo_nc_inv.sv
// Bench for xoodoo_nc_inv: a forward-permutation model feeds the inverse, and a cycle model plus an expected queue check every output.
// Directed round-trips, back-to-back, reset abort, a ROUNDS=1 build, and random jobs.
module tb_xoodoo_nc_inv;

  localparam int ROUNDS = 3;
  localparam logic [31:0] RC_TAB [12] = '{32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14,
                                          32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [95:0] cur_pre;
  logic [95:0] exp_q[$];
  logic        m_live = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ov   = 1'b0;
  logic [95:0] m_out  = '0;
  int          m_cnt  = 0;

  xoodoo_nc_inv_if bus ();
  xoodoo_nc_inv_if bus1 ();

  xoodoo_nc_inv #(.ROUNDS(3), .FIRST_RC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  xoodoo_nc_inv #(.ROUNDS(1), .FIRST_RC(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- forward reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [95:0] fwd_round(input logic [95:0] s, input logic [31:0] rc);
    logic [31:0] a0, a1, a2, p, e, b0, b1, b2;
    a0 = s[31:0]; a1 = s[63:32]; a2 = s[95:64];
    p  = a0 ^ a1 ^ a2;
    e  = rotl(p, 5) ^ rotl(p, 14);
    a0 = a0 ^ e; a1 = a1 ^ e; a2 = a2 ^ e;
    a2 = rotl(a2, 11);
    a0 = a0 ^ rc;
    b0 = ~a1 & a2; b1 = ~a2 & a0; b2 = ~a0 & a1;
    a0 = a0 ^ b0; a1 = a1 ^ b1; a2 = a2 ^ b2;
    a1 = rotl(a1, 1);
    a2 = rotl(a2, 8);
    return {a2, a1, a0};
  endfunction

  function automatic logic [95:0] fwd(input logic [95:0] s, input int rounds, input int first);
    logic [95:0] t;
    t = s;
    for (int r = 0; r < rounds; r++) t = fwd_round(t, RC_TAB[first + r]);
    return t;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0),
            $urandom_range(32'hFFFF_FFFF, 0)};
  endfunction

  // ---------------- cycle model + scoreboard for the ROUNDS=3 DUT ----------------
  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_ov   = 1'b0;
      m_out  = '0;
      m_cnt  = 0;
      exp_q.delete();
    end else if (m_live) begin
      m_ov = 1'b0;
      if (!m_busy) begin
        if (bus.dv) begin
          exp_q.push_back(cur_pre);
          m_busy = 1'b1;
          m_cnt  = ROUNDS - 1;
        end
      end else if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_ov   = 1'b1;
        if (exp_q.size() > 0) m_out = exp_q.pop_front();
      end else begin
        m_cnt--;
      end
    end
    #1;
    if (m_live) begin
      check("busy", {95'd0, bus.busy}, {95'd0, m_busy});
      check("out_valid", {95'd0, bus.out_valid}, {95'd0, m_ov});
      check("out", bus.out, m_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic roundtrip(input logic [95:0] s);
    int lat;
    int busy_cycles;
    lat = -1;
    busy_cycles = 0;
    cur_pre   = s;
    bus.state = fwd(s, 3, 8);
    bus.dv    = 1'b1;
    tick();
    bus.dv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cycles++;
      tick();
    end
    check("rt_latency", 96'(lat), 96'd3);
    check("rt_busy_cycles", 96'(busy_cycles), 96'd3);
    check("rt_out", bus.out, s);
    tick();
    check("rt_pulse_end", {95'd0, bus.out_valid}, 96'd0);
    check("rt_out_hold", bus.out, s);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [95:0] s;
    logic [95:0] a5;
    rst        = 1'b1;
    bus.dv     = 1'b0;
    bus.state  = '0;
    bus1.dv    = 1'b0;
    bus1.state = '0;
    cur_pre    = '0;
    repeat (3) tick();
    check("reset_busy", {95'd0, bus.busy}, 96'd0);
    check("reset_out_valid", {95'd0, bus.out_valid}, 96'd0);
    check("reset_out", bus.out, 96'd0);
    check("reset_out_r1", bus1.out, 96'd0);
    rst = 1'b0;
    tick();

    // Directed round-trips
    roundtrip(96'h0);
    roundtrip({96{1'b1}});
    roundtrip(96'h0123456789ABCDEF_FEDCBA98);
    roundtrip(96'h1);

    // Back-to-back with dv held high; junk state during busy must be ignored
    for (int j = 0; j < 4; j++) begin
      s         = rand96();
      cur_pre   = s;
      bus.state = fwd(s, 3, 8);
      bus.dv    = 1'b1;
      tick();
      bus.state = rand96();
      cur_pre   = rand96();
      repeat (3) tick();
    end
    bus.dv = 1'b0;
    repeat (4) tick();

    // Reset mid-job aborts with no out_valid
    s         = 96'hCAFEF00D_12345678_9ABCDEF0;
    cur_pre   = s;
    bus.state = fwd(s, 3, 8);
    bus.dv    = 1'b1;
    tick();
    bus.dv = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", {95'd0, bus.busy}, 96'd0);
    check("abort_out_valid", {95'd0, bus.out_valid}, 96'd0);
    check("abort_out", bus.out, 96'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_valid", {95'd0, bus.out_valid}, 96'd0);
    end
    roundtrip(96'h0BAD_F00D_DEAD_BEEF_0000_1111);

    // ROUNDS=1 build: single round with RC_8, latency 1
    a5         = {12{8'hA5}};
    bus1.state = fwd(a5, 1, 8);
    bus1.dv    = 1'b1;
    tick();
    bus1.dv = 1'b0;
    check("r1_busy", {95'd0, bus1.busy}, 96'd1);
    check("r1_valid_early", {95'd0, bus1.out_valid}, 96'd0);
    tick();
    check("r1_valid", {95'd0, bus1.out_valid}, 96'd1);
    check("r1_out", bus1.out, a5);
    check("r1_busy_done", {95'd0, bus1.busy}, 96'd0);
    tick();
    check("r1_pulse_end", {95'd0, bus1.out_valid}, 96'd0);
    check("r1_out_hold", bus1.out, a5);

    // Random jobs, one every ROUNDS+1 cycles
    for (int j = 0; j < 1000; j++) begin
      s         = rand96();
      cur_pre   = s;
      bus.state = fwd(s, 3, 8);
      bus.dv    = 1'b1;
      tick();
      bus.dv = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    check("queue_empty", 96'(exp_q.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/xoodoo_nc_inv.md
Name: xoodoo_nc_inv

Overview:
- Iterative inverse of the team's 3-lane (96-bit, 32-bit lanes) reduced-round Xoodoo-NC permutation: for any S, recovers S from the forward block's output.
- Sits on the decrypt/unmask side, downstream of whatever stored or transmitted the forward output.
- Computes one inverse round per clock to save area relative to the unrolled forward datapath.
- Uses a dv/out_valid strobe interface with a busy indication.

Parameters:
- ROUNDS, 3, number of inverse rounds (1..12); must equal the forward block's round count.
- FIRST_RC, 8, index of the round constant used by the forward block's first round; ROUNDS+FIRST_RC <= 12.
- RC_0..RC_11, 32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14, 32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12; round constants, identical to the forward block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dv  in  1  input strobe; accepted only when busy=0
- state  in  96  permuted state; lane0=[31:0], lane1=[63:32], lane2=[95:64]
- busy  out  1  high while a job is in flight
- out  out  96  recovered pre-permutation state, same lane packing
- out_valid  out  1  one-cycle pulse when out is updated

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at an edge) sets busy=0, out_valid=0, out=0, round counter=0, work register=0. Reset wins over all other inputs. Reset mid-job aborts the job with no out_valid.
- FSM states:
  - IDLE (busy=0). On a dv=1 edge: work<=state, cnt<=ROUNDS-1, busy<=1.
  - RUN (busy=1). Each edge: work<=inv_round(work, RC[FIRST_RC+cnt]) and cnt<=cnt-1.
  - On the RUN edge where cnt==0: out<=inv_round(...), out_valid<=1, busy<=0, return to IDLE.
- Latency and throughput: dv sampled at edge N gives out_valid high for the cycle after edge N+ROUNDS. Throughput is one job per ROUNDS+1 cycles.
- dv while busy=1, including on the completing edge, is ignored; no queueing. dv the cycle after out_valid is accepted.
- out_valid is high for exactly one cycle. out holds its value until the next completion or reset.
- inv_round(A0,A1,A2, RC), in this order:
  1. rho-east inverse: A1=rotr(A1,1); A2=rotr(A2,8).
  2. chi inverse: 3-lane chi is an involution, so Bi=~A(i+1 mod 3)&A(i+2 mod 3), computed from the pre-update lanes; then Ai^=Bi.
  3. iota: A0^=RC.
  4. rho-west inverse: A2=rotr(A2,11).
  5. theta inverse:
     - Pp=A0^A1^A2.
     - P=f^31(Pp), where f(v)=v^rotl(v,5)^rotl(v,14). Implement as the chain g(5,14), g(10,28), g(20,24), g(8,16), then rotl by 16, where g(a,b)(v)=v^rotl(v,a)^rotl(v,b).
     - E=P^Pp.
     - Ai^=E for all three lanes.
- Constants are applied in descending index: RC_(FIRST_RC+ROUNDS-1) first, RC_FIRST_RC last. Defaults: RC_10, RC_9, RC_8.
- All rotations are modulo 32 within a lane.
- One inv_round instance is shared across iterations; it is purely combinational from work and cnt.

Test Plan:
- Round-trip: bench instantiates the forward block with matching defaults. For S in {96'h0, {96{1'b1}}, 96'h0123456789ABCDEF_FEDCBA98, 96'h1}: forward(S) -> dv on inverse -> out==S, out_valid exactly 3 cycles after the dv sample edge, busy high for 3 cycles.
- Theta inverse unit check: for P in {32'h1, 32'h80000000, 32'hDEADBEEF}, Pp=f(P) -> inverse chain returns P.
- Back-to-back: dv held high continuously with 4 random states -> jobs accepted every 4 cycles; dv during busy ignored; each out matches the golden forward pre-image; out_valid is a single-cycle pulse each time.
- Reset mid-job: dv at edge 0, rst=1 at edge 2 -> no out_valid, out=0, busy=0. A subsequent dv completes correctly.
- ROUNDS=1, FIRST_RC=8 build: forward single round with RC_8 on 96'hA5A5..A5 -> inverse returns it, latency 1.
- Random: 1000 random states through forward then inverse -> all match, no out_valid without a prior accepted dv.
